// File: rtl/pe_feed_pkg.sv
// Shared types and helpers for the PE feed scheduler.
// Frame geometry defaults mirror the scheduler's default parameters.
package pe_feed_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSwap,
    StFetch,
    StEmit,
    StDone
  } state_e;

  localparam int unsigned IMG_H_DEF  = 32;
  localparam int unsigned PAD_DEF    = 1;
  localparam int unsigned TOTAL_ROWS = IMG_H_DEF + 2 * PAD_DEF;

  // Padded-frame row r is all padding above or below the image body.
  function automatic logic is_pad_row(input int unsigned r, input int unsigned img_h,
                                      input int unsigned pad);
    return (r < pad) || (r >= img_h + pad);
  endfunction

endpackage

// File: rtl/pe_feed_scheduler.sv
// Frame-level sequencer: swaps ping-pong halves, then walks the padded frame,
// fetching each image row and offering every row to the PE array.
module pe_feed_scheduler
  import pe_feed_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned PAD    = 1,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ROW_W  = $clog2(IMG_H + 2 * PAD)
) (
  input  logic              PEclk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_buf_ready,
  output logic              o_swap,
  output logic              o_fetch_req,
  output logic [ADDR_W-1:0] o_fetch_addr,
  input  logic              i_fetch_ack,
  output logic              o_row_vld,
  input  logic              i_row_rdy,
  output logic [ROW_W-1:0]  o_row_idx,
  output logic              o_row_pad,
  output logic              o_row_last,
  output logic              o_frame_done,
  output logic              o_busy,
  output logic              o_ovf
);

  localparam int unsigned TotalRows = IMG_H + 2 * PAD;

  state_e            r_state, w_state_nxt;
  logic [ROW_W-1:0]  r_row_idx, w_row_idx_nxt, w_row_inc;
  logic              r_pending, w_pending_nxt;
  logic              r_ovf, w_ovf_nxt;
  logic              w_start;
  logic              w_row_last;
  logic [ADDR_W-1:0] w_img_row, w_addr;

  assign w_start    = (r_state == StIdle) && i_en && (i_buf_ready || r_pending);
  assign w_row_inc  = r_row_idx + ROW_W'(1);
  assign w_row_last = (r_row_idx == ROW_W'(TotalRows - 1));

  // Image row index may wrap negative on padding rows; the address is only shown in FETCH.
  assign w_img_row = ADDR_W'(r_row_idx) - ADDR_W'(PAD);

  if ((IMG_W & (IMG_W - 1)) == 0) begin : g_shift
    assign w_addr = w_img_row << $clog2(IMG_W);
  end else begin : g_mul
    assign w_addr = w_img_row * ADDR_W'(IMG_W);
  end

  // A start consumes one request; a buf_ready landing on an already-pending one stays queued.
  always_comb begin
    w_pending_nxt = r_pending;
    w_ovf_nxt     = r_ovf;
    if (w_start) begin
      w_pending_nxt = r_pending & i_buf_ready;
    end else if (i_buf_ready) begin
      if (r_pending) begin
        w_ovf_nxt = 1'b1;
      end
      w_pending_nxt = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_idx_nxt = r_row_idx;
    unique case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_nxt = StSwap;
        end
      end
      StSwap: begin
        w_row_idx_nxt = '0;
        w_state_nxt   = is_pad_row(0, IMG_H, PAD) ? StEmit : StFetch;
      end
      StFetch: begin
        if (i_fetch_ack) begin
          w_state_nxt = StEmit;
        end
      end
      StEmit: begin
        if (i_row_rdy) begin
          if (w_row_last) begin
            w_state_nxt = StDone;
          end else begin
            w_row_idx_nxt = w_row_inc;
            w_state_nxt   = is_pad_row(32'(w_row_inc), IMG_H, PAD) ? StEmit : StFetch;
          end
        end
      end
      StDone: begin
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge PEclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_row_idx <= '0;
      r_pending <= 1'b0;
      r_ovf     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_row_idx <= w_row_idx_nxt;
      r_pending <= w_pending_nxt;
      r_ovf     <= w_ovf_nxt;
    end
  end

  assign o_swap       = (r_state == StSwap);
  assign o_fetch_req  = (r_state == StFetch);
  assign o_row_vld    = (r_state == StEmit);
  assign o_frame_done = (r_state == StDone);
  assign o_busy       = (r_state != StIdle);
  assign o_fetch_addr = o_fetch_req ? w_addr : '0;
  assign o_row_idx    = r_row_idx;
  assign o_row_pad    = is_pad_row(32'(r_row_idx), IMG_H, PAD);
  assign o_row_last   = w_row_last;
  assign o_ovf        = r_ovf;

endmodule

// File: tb/tb_pe_feed_scheduler.sv
// Bench for pe_feed_scheduler: expected per-frame event list built from the row rules,
// checked against the strobes every cycle, plus directed timing checks.
module tb_pe_feed_scheduler;

  localparam int IMG_W  = 32;
  localparam int IMG_H  = 32;
  localparam int PAD    = 1;
  localparam int ADDR_W = 16;
  localparam int ROW_W  = 6;
  localparam int TOTAL  = IMG_H + 2 * PAD;
  localparam int MAXCYC = 400;

  logic              PEclk = 1'b0;
  logic              rst_n;
  logic              i_en, i_buf_ready, i_fetch_ack, i_row_rdy;
  logic              o_swap, o_fetch_req, o_row_vld, o_row_pad, o_row_last;
  logic              o_frame_done, o_busy, o_ovf;
  logic [ADDR_W-1:0] o_fetch_addr;
  logic [ROW_W-1:0]  o_row_idx;

  always #5 PEclk = ~PEclk;

  pe_feed_scheduler #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PAD   (PAD),
    .ADDR_W(ADDR_W),
    .ROW_W (ROW_W)
  ) dut (
    .PEclk       (PEclk),
    .rst_n       (rst_n),
    .i_en        (i_en),
    .i_buf_ready (i_buf_ready),
    .o_swap      (o_swap),
    .o_fetch_req (o_fetch_req),
    .o_fetch_addr(o_fetch_addr),
    .i_fetch_ack (i_fetch_ack),
    .o_row_vld   (o_row_vld),
    .i_row_rdy   (i_row_rdy),
    .o_row_idx   (o_row_idx),
    .o_row_pad   (o_row_pad),
    .o_row_last  (o_row_last),
    .o_frame_done(o_frame_done),
    .o_busy      (o_busy),
    .o_ovf       (o_ovf)
  );

  typedef enum int {EvSwap = 0, EvFetch = 1, EvRow = 2, EvDone = 3} ev_e;
  typedef struct {
    ev_e kind;
    int  val;
    bit  pad;
    bit  last;
  } ev_t;

  ev_t q[$];
  int  nvec = 0;
  int  nfail = 0;
  int  cyc = 0;
  int  swap_cyc = -1, done_cyc = -1, idle_cyc = -1, ovf_cyc = -1;
  bit  prev_busy = 1'b0;
  int  t0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One frame as the block should present it: swap, rows in order with a fetch before each
  // image row, then frame_done.
  function automatic void push_frame();
    ev_t e;
    bit  p;
    e.kind = EvSwap; e.val = 0; e.pad = 1'b0; e.last = 1'b0;
    q.push_back(e);
    for (int r = 0; r < TOTAL; r++) begin
      p = (r < PAD) || (r >= IMG_H + PAD);
      if (!p) begin
        e.kind = EvFetch; e.val = (r - PAD) * IMG_W; e.pad = 1'b0; e.last = 1'b0;
        q.push_back(e);
      end
      e.kind = EvRow; e.val = r; e.pad = p; e.last = (r == TOTAL - 1);
      q.push_back(e);
    end
    e.kind = EvDone; e.val = 0; e.pad = 1'b0; e.last = 1'b0;
    q.push_back(e);
  endfunction

  task automatic observe();
    logic [3:0] s;
    int         k;
    ev_t        h;
    s = {o_swap, o_fetch_req, o_row_vld, o_frame_done};
    chk("busy_vs_strobes", {31'b0, o_busy}, {31'b0, |s});
    if (s != 4'b0) begin
      chk("one_strobe", $countones(s), 1);
      if (o_swap) swap_cyc = cyc;
      if (o_frame_done) done_cyc = cyc;
      k = o_swap ? 0 : o_fetch_req ? 1 : o_row_vld ? 2 : 3;
      if (q.size() == 0) begin
        chk("unexpected_strobe", {28'b0, s}, 0);
      end else begin
        h = q[0];
        chk("event_kind", k, h.kind);
        if (h.kind == EvFetch && o_fetch_req) chk("fetch_addr", {16'b0, o_fetch_addr}, h.val);
        if (h.kind == EvRow && o_row_vld) begin
          chk("row_idx", {26'b0, o_row_idx}, h.val);
          chk("row_pad", {31'b0, o_row_pad}, {31'b0, h.pad});
          chk("row_last", {31'b0, o_row_last}, {31'b0, h.last});
        end
      end
    end
    if (o_ovf && ovf_cyc < 0) ovf_cyc = cyc;
    if (prev_busy && !o_busy) idle_cyc = cyc;
    prev_busy = o_busy;
  endtask

  task automatic step(input bit rdy, input bit ack, input bit br);
    observe();
    i_row_rdy   = rdy;
    i_fetch_ack = ack;
    i_buf_ready = br;
    if (q.size() != 0) begin
      if ((o_swap && q[0].kind == EvSwap) || (o_frame_done && q[0].kind == EvDone) ||
          (o_fetch_req && ack && q[0].kind == EvFetch) ||
          (o_row_vld && rdy && q[0].kind == EvRow)) begin
        void'(q.pop_front());
      end
    end
    @(negedge PEclk);
    cyc++;
  endtask

  // mode 0: no stalls, 1: random stalls, 2: rdy held low on row 5, ack late on row 10.
  task automatic run(input int mode, input int br1, input int br2, input int br3,
                     input int en_drop, input bit stop12);
    int n, h5, h10;
    bit rdy, ack;
    n = 0; h5 = 0; h10 = 0;
    while ((q.size() != 0 || o_busy) && n < MAXCYC) begin
      if (stop12 && o_fetch_req && o_row_idx == 12) break;
      rdy = 1'b1;
      ack = 1'b1;
      if (mode == 1) begin
        rdy = ($urandom_range(0, 3) != 0);
        ack = ($urandom_range(0, 2) != 0);
      end
      if (mode == 2) begin
        if (o_row_vld && o_row_idx == 5 && h5 < 3) begin rdy = 1'b0; h5++; end
        if (o_fetch_req && o_row_idx == 10 && h10 < 4) begin ack = 1'b0; h10++; end
      end
      if (n == en_drop) i_en = 1'b0;
      step(rdy, ack, (n == br1) || (n == br2) || (n == br3));
      n++;
    end
    chk("run_bounded", {31'b0, n < MAXCYC}, 1);
    observe();
  endtask

  initial begin
    rst_n = 1'b0; i_en = 1'b1; i_buf_ready = 1'b0; i_fetch_ack = 1'b0; i_row_rdy = 1'b0;
    repeat (3) @(negedge PEclk);
    chk("rst_swap", {31'b0, o_swap}, 0);
    chk("rst_fetch_req", {31'b0, o_fetch_req}, 0);
    chk("rst_row_vld", {31'b0, o_row_vld}, 0);
    chk("rst_frame_done", {31'b0, o_frame_done}, 0);
    chk("rst_busy", {31'b0, o_busy}, 0);
    chk("rst_ovf", {31'b0, o_ovf}, 0);
    chk("rst_row_idx", {26'b0, o_row_idx}, 0);
    chk("rst_row_pad", {31'b0, o_row_pad}, 1);
    chk("rst_row_last", {31'b0, o_row_last}, 0);
    rst_n = 1'b1;
    @(negedge PEclk);

    // Zero-stall frame.
    t0 = cyc;
    push_frame();
    run(0, 0, -1, -1, -1, 1'b0);
    chk("f1_swap_t", swap_cyc, t0 + 1);
    chk("f1_done_t", done_cyc, t0 + 68);
    chk("f1_idle_t", idle_cyc, t0 + 69);

    // Backpressure on row 5 and a late ack on row 10.
    t0 = cyc;
    push_frame();
    run(2, 0, -1, -1, -1, 1'b0);
    chk("bp_done_t", done_cyc, t0 + 75);

    // Back-to-back: second request lands mid-frame and waits in pending.
    t0 = cyc;
    push_frame();
    push_frame();
    run(0, 0, 20, -1, -1, 1'b0);
    chk("b2b_swap2_t", swap_cyc, t0 + 70);
    chk("b2b_done2_t", done_cyc, t0 + 137);
    chk("b2b_no_ovf", {31'b0, o_ovf}, 0);

    // Randomly stalled frames.
    repeat (3) begin
      push_frame();
      run(1, 0, -1, -1, -1, 1'b0);
    end
    chk("rand_no_ovf", {31'b0, o_ovf}, 0);

    // Overflow: third request while one is pending is dropped; only one extra frame.
    t0 = cyc;
    ovf_cyc = -1;
    push_frame();
    push_frame();
    run(1, 0, 20, 30, -1, 1'b0);
    chk("ovf_rise_t", ovf_cyc, t0 + 31);
    chk("ovf_sticky_end", {31'b0, o_ovf}, 1);

    // en=0 holds the request; raising en starts next cycle; dropping en mid-frame is ignored.
    swap_cyc = -1;
    i_en = 1'b0;
    push_frame();
    step(1'b1, 1'b1, 1'b1);
    repeat (9) step(1'b1, 1'b1, 1'b0);
    chk("en0_no_swap", swap_cyc, -1);
    i_en = 1'b1;
    t0 = cyc;
    run(0, -1, -1, -1, 15, 1'b0);
    chk("en_swap_t", swap_cyc, t0 + 1);
    chk("en_drop_done_t", done_cyc, t0 + 68);
    i_en = 1'b1;

    // Reset during the row-12 fetch abandons the frame and clears ovf.
    push_frame();
    run(1, 0, -1, -1, -1, 1'b1);
    chk("pre_rst_fetch12", {31'b0, o_fetch_req && o_row_idx == 12}, 1);
    chk("pre_rst_ovf", {31'b0, o_ovf}, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_fetch_req", {31'b0, o_fetch_req}, 0);
    chk("mid_rst_row_vld", {31'b0, o_row_vld}, 0);
    chk("mid_rst_swap", {31'b0, o_swap}, 0);
    chk("mid_rst_done", {31'b0, o_frame_done}, 0);
    chk("mid_rst_busy", {31'b0, o_busy}, 0);
    chk("mid_rst_row_idx", {26'b0, o_row_idx}, 0);
    chk("mid_rst_addr", {16'b0, o_fetch_addr}, 0);
    chk("mid_rst_ovf", {31'b0, o_ovf}, 0);
    q.delete();
    prev_busy = 1'b0;
    i_buf_ready = 1'b0; i_fetch_ack = 1'b0; i_row_rdy = 1'b0;
    @(negedge PEclk);
    cyc++;
    rst_n = 1'b1;
    @(negedge PEclk);
    cyc++;
    t0 = cyc;
    push_frame();
    run(1, 0, -1, -1, -1, 1'b0);
    chk("post_rst_swap_t", swap_cyc, t0 + 1);
    chk("post_rst_ovf", {31'b0, o_ovf}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
